// File: rtl/uart_tx_fifo_pkg.sv
// Shared types for the buffered UART transmit path: byte width and the
// handshake controller state encoding used by uart_tx_fifo.
package uart_tx_fifo_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Circular byte FIFO with explicit occupancy count, sticky overflow flag and
// a registered read port. Optional flush input when UART_TX_FIFO_FLUSH_EN is defined.
module uart_sync_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     srst,
`ifdef UART_TX_FIFO_FLUSH_EN
    input  logic                     flush,
`endif
    input  logic [BYTE_W-1:0]        wr_data,
    input  logic                     wr_en,
    input  logic                     pop,
    input  logic                     clr_overflow,
    output logic [BYTE_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [BYTE_W-1:0] rd_data_q;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              flush_req;
    logic              wr_ok;
    logic              pop_ok;

`ifdef UART_TX_FIFO_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    assign full  = (count_q == COUNT_FULL);
    assign empty = (count_q == '0);

    // Acceptance is decided by the occupancy at this edge; a concurrent pop
    // does not free a slot for the same cycle's write.
    assign wr_ok  = wr_en && !full && !flush_req;
    assign pop_ok = pop && !empty && !flush_req;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({wr_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (wr_en && full && !flush_req) begin
            overflow_d = 1'b1;
        end
        if (clr_overflow) begin
            overflow_d = 1'b0;
        end

        if (flush_req) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // Registered read doubles as the transmit data holding register.
    always_ff @(posedge clk) begin
        if (srst) begin
            rd_data_q <= '0;
        end else if (pop_ok) begin
            rd_data_q <= mem[rd_ptr_q];
        end
    end

    assign rd_data  = rd_data_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte-buffered UART transmit feeder: FIFO plus TxBegin/TxBusy handshake
// controller. Define UART_TX_FIFO_FLUSH_EN to add the Flush input.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int BUSY_WAIT = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
`ifdef UART_TX_FIFO_FLUSH_EN
    input  logic                     Flush,
`endif
    input  logic [BYTE_W-1:0]        WrData,
    input  logic                     WrEn,
    output logic                     Full,
    output logic                     Empty,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Overflow,
    input  logic                     ClearOverflow,
    output logic                     TxBegin,
    output logic [BYTE_W-1:0]        TxData,
    input  logic                     TxBusy
);

    localparam int WW = $clog2(BUSY_WAIT + 1);
    localparam logic [WW-1:0] WAIT_LIMIT = WW'(BUSY_WAIT);

    tx_state_e     state_q;
    logic          tx_begin_q;
    logic [WW-1:0] wait_cnt_q;
    logic [WW-1:0] wait_cnt_inc;
    logic          fifo_empty;
    logic          fifo_pop;
    logic          flush_req;

`ifdef UART_TX_FIFO_FLUSH_EN
    assign flush_req = Flush;
`else
    assign flush_req = 1'b0;
`endif

    // A launch pops the FIFO; the popped byte lands in the read register,
    // which is exactly what TxData shows from the START cycle onward.
    assign fifo_pop     = (state_q == IDLE) && !fifo_empty && !flush_req;
    assign wait_cnt_inc = wait_cnt_q + 1'b1;

    uart_sync_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk          (CLK),
        .srst         (RST),
`ifdef UART_TX_FIFO_FLUSH_EN
        .flush        (Flush),
`endif
        .wr_data      (WrData),
        .wr_en        (WrEn),
        .pop          (fifo_pop),
        .clr_overflow (ClearOverflow),
        .rd_data      (TxData),
        .full         (Full),
        .empty        (fifo_empty),
        .count        (Count),
        .overflow     (Overflow)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            tx_begin_q <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            tx_begin_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fifo_pop) begin
                        state_q    <= START;
                        tx_begin_q <= 1'b1;
                    end
                end
                START: begin
                    state_q    <= WAIT_BUSY;
                    wait_cnt_q <= '0;
                end
                WAIT_BUSY: begin
                    if (TxBusy) begin
                        state_q <= WAIT_DONE;
                    end else begin
                        // Transmitter never acknowledged: drop the byte, no retry.
                        wait_cnt_q <= wait_cnt_inc;
                        if (wait_cnt_inc == WAIT_LIMIT) begin
                            state_q <= IDLE;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (!TxBusy) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign TxBegin = tx_begin_q;
    assign Empty   = fifo_empty;

endmodule
